dtc_stub_demux: RTL and testbench
=================================

DTC_STUB_DEMUX -- requirements
Module: dtc_stub_demux

Interface
REQ-001 SHALL have parameter FRAME_W, default 256: input frame width in bits.
REQ-002 SHALL have parameter HDR_W, default 46: header field width at frame MSBs.
REQ-003 SHALL have parameter N_PKT, default 10: packets per frame.
REQ-004 SHALL have parameter PKT_W, default 21: packet width; chip ID occupies packet MSBs.
REQ-005 SHALL have parameter CHIP_W, default 3: chip ID field width.
REQ-006 SHALL have parameter N_CHIP, default 8: number of per-chip output stores (N_CHIP <= 2**CHIP_W).
REQ-007 SHALL have parameter ADDR_W, default 7: per-chip store address width.
REQ-008 SHALL have parameter HDR_CHECK, default 1: 1 = drop frames whose header differs from HDR_PATTERN; 0 = accept all frames.
REQ-009 SHALL have parameter HDR_PATTERN, default 46'h0: expected header value.
REQ-010 SHALL have port clk, input, 1: single clock, rising edge.
REQ-011 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-012 SHALL have port in_valid, input, 1: frame present.
REQ-013 SHALL have port in_frame, input, FRAME_W: frame data.
REQ-014 SHALL have port in_ready, output, 1: frame accepted when in_valid && in_ready.
REQ-015 SHALL have port flush, input, 1: synchronous clear of all per-chip write addresses.
REQ-016 SHALL have port wr_en, output, N_CHIP: one-hot write strobe to the selected chip store.
REQ-017 SHALL have port wr_addr, output, ADDR_W: write address of the strobed chip.
REQ-018 SHALL have port wr_data, output, PKT_W: full packet, including the chip ID.
REQ-019 SHALL have port frame_done, output, 1: one-cycle pulse after the last packet of a frame is processed.
REQ-020 SHALL have port wrap, output, N_CHIP: sticky per-chip flag, set when that chip's address wraps.
REQ-021 SHALL have port bad_hdr_cnt, output, 8: saturating count of dropped frames.
REQ-022 SHALL have port bad_chip_cnt, output, 8: saturating count of packets with chip ID >= N_CHIP.
REQ-023 SHALL have port frame_cnt, output, 16: wrapping count of accepted good frames.

Function
REQ-024 SHALL elaborate only if HDR_W + N_PKT*PKT_W == FRAME_W; any other combination is an elaboration error.
REQ-025 SHALL implement FSM states IDLE and EXTRACT.
REQ-026 SHALL drive in_ready=1 in IDLE, and in EXTRACT only on the cycle with pkt_idx == N_PKT-1, so that frames stream back-to-back.
REQ-027 SHALL register in_frame on acceptance; with a good header the FSM goes to EXTRACT with pkt_idx=0.
REQ-028 SHALL, for a bad header with HDR_CHECK=1, stay in/return to IDLE, increment bad_hdr_cnt, and produce no writes and no frame_done.
REQ-029 SHALL process packet k in EXTRACT cycle k, where packet 0 is bits [FRAME_W-HDR_W-1 -: PKT_W] and each subsequent packet is the next PKT_W bits toward the LSB.
REQ-030 SHALL drive all outputs from registers: a packet processed in cycle T appears on wr_en/wr_addr/wr_data in cycle T+1, and the first write occurs 2 cycles after acceptance.
REQ-031 SHALL, for a packet with chip ID c < N_CHIP, assert wr_en[c], drive wr_addr = addr[c], then increment addr[c].
REQ-032 SHALL wrap addr[c] from 2**ADDR_W-1 to 0 and set wrap[c] on that wrap.
REQ-033 SHALL, for a packet with chip ID >= N_CHIP, produce no write and increment bad_chip_cnt.
REQ-034 SHALL, after processing packet N_PKT-1, pulse frame_done once and increment frame_cnt; the FSM then goes to EXTRACT if a frame is accepted in the same cycle, else to IDLE.
REQ-035 SHALL hold both 8-bit counters at 255 once reached; frame_cnt wraps from 65535 to 0.
REQ-036 SHALL, when flush is asserted, zero all addr[] and wrap[] at the next edge; flush has priority over a same-cycle increment, and the concurrent write itself is still issued.
REQ-037 SHALL deassert wr_en (all zeros) on every cycle without a valid write.

Reset
REQ-038 SHALL, when rst is asserted, immediately set: state=IDLE, pkt_idx=0, in_ready=1 (after release), wr_en=0, wr_addr=0, wr_data=0, frame_done=0, wrap=0, all addr[]=0, and all counters=0.
REQ-039 SHALL, when rst is asserted mid-frame, abandon the frame with no further writes and no frame_done.

Structure
REQ-040 SHALL take the parameter defaults and the state encoding (IDLE, EXTRACT) from the shared package dtc_pkg.
REQ-041 SHALL use sub-module dtc_sat_cnt (parametrised width, increment, synchronous clear) for bad_hdr_cnt and bad_chip_cnt.

Verification
REQ-042 Bench SHALL cover: one good frame with packets carrying chip IDs 0..7,0,1 -> wr_en one-hot in order, chips 0/1 at addr 0 then 1, others at addr 0, frame_done 11 cycles after acceptance, frame_cnt=1.
REQ-043 Bench SHALL cover: in_valid held high for 3 frames -> 30 consecutive write cycles with no gaps, and 3 frame_done pulses 10 cycles apart.
REQ-044 Bench SHALL cover: HDR_CHECK=1 with header 46'h1 -> no writes, bad_hdr_cnt=1, in_ready stays 1.
REQ-045 Bench SHALL cover: N_CHIP=6 with packets carrying chip ID 6 and 7 -> no write for those packets, bad_chip_cnt=2.
REQ-046 Bench SHALL cover: 13 frames all carrying chip 0 (130 packets) -> addr wraps 127->0, wrap[0]=1; a following flush -> wrap[0]=0 and the next chip-0 write goes to addr 0.
REQ-047 Bench SHALL cover: rst asserted at EXTRACT pkt_idx=4 -> wr_en=0 immediately, no frame_done, and a new frame after release restarts at packet 0.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared definitions for the DTC stub demultiplexer: parameter defaults,
// FSM state encoding and a small width helper.
package dtc_pkg;

    localparam int          DTC_FRAME_W     = 256;
    localparam int          DTC_HDR_W       = 46;
    localparam int          DTC_N_PKT       = 10;
    localparam int          DTC_PKT_W       = 21;
    localparam int          DTC_CHIP_W      = 3;
    localparam int          DTC_N_CHIP      = 8;
    localparam int          DTC_ADDR_W      = 7;
    localparam int          DTC_HDR_CHECK   = 1;
    localparam logic [45:0] DTC_HDR_PATTERN = 46'h0;

    typedef enum logic {
        IDLE    = 1'b0,
        EXTRACT = 1'b1
    } dtc_state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int dtc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtc_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for the error counters.
module dtc_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dtc_stub_demux.sv
// Splits header-tagged frames into fixed-width packets and routes each packet
// to a per-chip store by the chip ID in its MSBs, one packet per cycle.
module dtc_stub_demux
    import dtc_pkg::*;
#(
    parameter int               FRAME_W     = DTC_FRAME_W,
    parameter int               HDR_W       = DTC_HDR_W,
    parameter int               N_PKT       = DTC_N_PKT,
    parameter int               PKT_W       = DTC_PKT_W,
    parameter int               CHIP_W      = DTC_CHIP_W,
    parameter int               N_CHIP      = DTC_N_CHIP,
    parameter int               ADDR_W      = DTC_ADDR_W,
    parameter int               HDR_CHECK   = DTC_HDR_CHECK,
    parameter logic [HDR_W-1:0] HDR_PATTERN = HDR_W'(DTC_HDR_PATTERN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [FRAME_W-1:0] in_frame,
    output logic               in_ready,
    input  logic               flush,
    output logic [N_CHIP-1:0]  wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PKT_W-1:0]   wr_data,
    output logic               frame_done,
    output logic [N_CHIP-1:0]  wrap,
    output logic [7:0]         bad_hdr_cnt,
    output logic [7:0]         bad_chip_cnt,
    output logic [15:0]        frame_cnt
);

    localparam int               PAY_W    = N_PKT * PKT_W;
    localparam int               IDX_W    = dtc_idx_w(N_PKT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PKT - 1);

    if (HDR_W + N_PKT * PKT_W != FRAME_W) begin : g_bad_geometry
        $error("dtc_stub_demux: HDR_W + N_PKT*PKT_W must equal FRAME_W");
    end
    if (N_CHIP > (1 << CHIP_W)) begin : g_bad_chip_count
        $error("dtc_stub_demux: N_CHIP exceeds the chip ID range");
    end

    dtc_state_t         state_q, state_d;
    logic [IDX_W-1:0]   pkt_idx_q;
    logic [PAY_W-1:0]   pay_q;
    logic [ADDR_W-1:0]  addr_q [N_CHIP];

    logic               processing;
    logic               last_pkt;
    logic               hdr_ok;
    logic               accept;
    logic               load;
    logic               bad_hdr;
    logic [PKT_W-1:0]   pkt;
    logic [CHIP_W-1:0]  chip;
    logic               chip_in_range;
    logic               chip_ok;
    logic               bad_chip;

    // The payload is shifted toward the MSBs so the current packet is always on top.
    assign pkt           = pay_q[PAY_W-1 -: PKT_W];
    assign chip          = pkt[PKT_W-1 -: CHIP_W];
    assign chip_in_range = int'(chip) < N_CHIP;
    assign chip_ok       = processing && chip_in_range;
    assign bad_chip      = processing && !chip_in_range;

    assign hdr_ok   = (HDR_CHECK == 0) || (in_frame[FRAME_W-1 -: HDR_W] == HDR_PATTERN);
    assign accept   = in_valid && in_ready;
    assign load     = accept && hdr_ok;
    assign bad_hdr  = accept && !hdr_ok;
    assign last_pkt = processing && (pkt_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = EXTRACT;
            EXTRACT: if (last_pkt) state_d = load ? EXTRACT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accepting on the last packet cycle lets frames stream with no bubble.
    always_comb begin
        in_ready   = 1'b0;
        processing = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            EXTRACT: begin
                processing = 1'b1;
                in_ready   = (pkt_idx_q == LAST_IDX);
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_idx_q <= '0;
            pay_q     <= '0;
        end else if (load) begin
            pkt_idx_q <= '0;
            pay_q     <= in_frame[PAY_W-1:0];
        end else if (processing) begin
            pkt_idx_q <= last_pkt ? '0 : pkt_idx_q + IDX_W'(1);
            pay_q     <= pay_q << PKT_W;
        end
    end

    // NOTE: addr_q is a small register bank, not a RAM, so it is reset with
    // everything else and a mid-run reset restarts every store at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            wrap       <= '0;
            frame_cnt  <= '0;
            for (int c = 0; c < N_CHIP; c++) begin
                addr_q[c] <= '0;
            end
        end else begin
            wr_en      <= '0;
            frame_done <= 1'b0;

            for (int c = 0; c < N_CHIP; c++) begin
                if (chip_ok && (chip == CHIP_W'(c))) begin
                    wr_en[c]  <= 1'b1;
                    wr_addr   <= addr_q[c];
                    wr_data   <= pkt;
                    addr_q[c] <= addr_q[c] + ADDR_W'(1);
                    if (addr_q[c] == {ADDR_W{1'b1}}) begin
                        wrap[c] <= 1'b1;
                    end
                end
            end

            if (last_pkt) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end

            // Placed last so it overrides any same-cycle increment or wrap.
            if (flush) begin
                wrap <= '0;
                for (int c = 0; c < N_CHIP; c++) begin
                    addr_q[c] <= '0;
                end
            end
        end
    end

    dtc_sat_cnt #(.W(8)) u_bad_hdr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (bad_hdr),
        .count (bad_hdr_cnt)
    );

    dtc_sat_cnt #(.W(8)) u_bad_chip_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (bad_chip),
        .count (bad_chip_cnt)
    );

endmodule

// File: tb/tb_dtc_stub_demux.sv
// Directed bench for dtc_stub_demux: default instance plus an N_CHIP=6 instance.
module tb_dtc_stub_demux;

    typedef logic [2:0] chips_t [10];

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         in_valid = 1'b0;
    logic [255:0] in_frame = '0;
    logic         flush    = 1'b0;
    logic         in_ready;
    logic [7:0]   wr_en;
    logic [6:0]   wr_addr;
    logic [20:0]  wr_data;
    logic         frame_done;
    logic [7:0]   wrap;
    logic [7:0]   bad_hdr_cnt;
    logic [7:0]   bad_chip_cnt;
    logic [15:0]  frame_cnt;

    logic         in_valid6 = 1'b0;
    logic [255:0] in_frame6 = '0;
    logic         flush6    = 1'b0;
    logic         in_ready6;
    logic [5:0]   wr_en6;
    logic [6:0]   wr_addr6;
    logic [20:0]  wr_data6;
    logic         frame_done6;
    logic [5:0]   wrap6;
    logic [7:0]   bad_hdr_cnt6;
    logic [7:0]   bad_chip_cnt6;
    logic [15:0]  frame_cnt6;

    int errors = 0;
    int checks = 0;

    logic [255:0] fq [$];
    int           w_cyc [$];
    logic [7:0]   w_en [$];
    logic [6:0]   w_addr [$];
    logic [20:0]  w_data [$];
    int           d_cyc [$];
    int           rdy_low;

    always #5 clk = ~clk;

    dtc_stub_demux u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_frame     (in_frame),
        .in_ready     (in_ready),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .wrap         (wrap),
        .bad_hdr_cnt  (bad_hdr_cnt),
        .bad_chip_cnt (bad_chip_cnt),
        .frame_cnt    (frame_cnt)
    );

    dtc_stub_demux #(.N_CHIP(6)) u_dut6 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid6),
        .in_frame     (in_frame6),
        .in_ready     (in_ready6),
        .flush        (flush6),
        .wr_en        (wr_en6),
        .wr_addr      (wr_addr6),
        .wr_data      (wr_data6),
        .frame_done   (frame_done6),
        .wrap         (wrap6),
        .bad_hdr_cnt  (bad_hdr_cnt6),
        .bad_chip_cnt (bad_chip_cnt6),
        .frame_cnt    (frame_cnt6)
    );

    // Packet k sits just below the header, stepping PKT_W bits toward the LSB.
    function automatic logic [255:0] mk_frame(input logic [45:0] hdr, input chips_t ch,
                                              input logic [17:0] seed);
        logic [255:0] f;
        f = '0;
        f[255 -: 46] = hdr;
        for (int k = 0; k < 10; k++) begin
            f[209 - 21*k -: 21] = {ch[k], seed + 18'(k)};
        end
        return f;
    endfunction

    // Streams fq back-to-back; sample i observes the i-th cycle after the first acceptance cycle.
    task automatic run_frames();
        int fi;
        int n_cyc;
        bit acc;
        w_cyc.delete(); w_en.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete();
        rdy_low = 0;
        fi      = 0;
        n_cyc   = 10 * fq.size() + 14;
        @(negedge clk);
        in_valid = 1'b1;
        in_frame = fq[0];
        acc      = in_ready;
        for (int i = 1; i <= n_cyc; i++) begin
            @(negedge clk);
            if (wr_en !== 8'h00) begin
                w_cyc.push_back(i); w_en.push_back(wr_en);
                w_addr.push_back(wr_addr); w_data.push_back(wr_data);
            end
            if (frame_done === 1'b1) d_cyc.push_back(i);
            if (in_ready !== 1'b1) rdy_low++;
            if (acc) begin
                fi++;
                if (fi < fq.size()) in_frame = fq[fi];
                else in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_en !== 8'h00 || wr_addr !== 7'h00 || wr_data !== 21'h0 || frame_done !== 1'b0 ||
            wrap !== 8'h00 || frame_cnt !== 16'h0 || bad_hdr_cnt !== 8'h00 || bad_chip_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got en=%h addr=%h data=%h done=%b wrap=%h fcnt=%h bh=%h bc=%h expected all zero",
                     wr_en, wr_addr, wr_data, frame_done, wrap, frame_cnt, bad_hdr_cnt, bad_chip_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        chips_t ch;
        int exp_addr [10];
        ch       = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        exp_addr = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        fq.delete();
        fq.push_back(mk_frame(46'h0, ch, 18'h00100));
        run_frames();
        checks++;
        if (w_cyc.size() != 10) begin
            errors++;
            $display("FAIL single_write_count: got %0d expected 10", w_cyc.size());
        end
        for (int k = 0; k < 10 && k < w_cyc.size(); k++) begin
            checks++;
            if (w_cyc[k] != k + 2 || w_en[k] !== 8'(1 << ch[k]) || w_addr[k] !== 7'(exp_addr[k]) ||
                w_data[k] !== {ch[k], 18'h00100 + 18'(k)}) begin
                errors++;
                $display("FAIL single_pkt%0d: got cyc=%0d en=%h addr=%0d data=%h expected cyc=%0d en=%h addr=%0d data=%h",
                         k, w_cyc[k], w_en[k], w_addr[k], w_data[k],
                         k + 2, 8'(1 << ch[k]), exp_addr[k], {ch[k], 18'h00100 + 18'(k)});
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != 11) begin
            errors++;
            $display("FAIL single_frame_done: got %0d pulses first at %0d expected 1 pulse at 11",
                     d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        chips_t ch;
        logic [17:0] seeds [3];
        int bad;
        ch    = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        seeds = '{18'h01000, 18'h01100, 18'h01200};
        fq.delete();
        for (int f = 0; f < 3; f++) fq.push_back(mk_frame(46'h0, ch, seeds[f]));
        run_frames();
        checks++;
        if (w_cyc.size() != 30) begin
            errors++;
            $display("FAIL b2b_write_count: got %0d expected 30", w_cyc.size());
        end
        // Chip 3 already holds one write from the single-frame test.
        bad = 0;
        for (int k = 0; k < w_cyc.size(); k++) begin
            if (w_cyc[k] != k + 2 || w_en[k] !== 8'h08 || w_addr[k] !== 7'(k + 1) ||
                w_data[k] !== {3'd3, seeds[k / 10] + 18'(k % 10)}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_write_stream: got %0d bad write cycles expected 0", bad);
        end
        checks++;
        if (d_cyc.size() != 3 || d_cyc[0] != 11 || d_cyc[1] != 21 || d_cyc[2] != 31) begin
            errors++;
            $display("FAIL b2b_frame_done: got %0d pulses expected 3 at cycles 11,21,31", d_cyc.size());
        end
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL b2b_frame_cnt: got %0d expected 4", frame_cnt);
        end
    endtask

    task automatic test_bad_header();
        chips_t ch;
        ch = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        fq.delete();
        fq.push_back(mk_frame(46'h1, ch, 18'h00200));
        run_frames();
        checks++;
        if (w_cyc.size() != 0 || d_cyc.size() != 0) begin
            errors++;
            $display("FAIL badhdr_activity: got writes=%0d done=%0d expected 0 and 0", w_cyc.size(), d_cyc.size());
        end
        checks++;
        if (rdy_low != 0) begin
            errors++;
            $display("FAIL badhdr_in_ready: got %0d low cycles expected 0", rdy_low);
        end
        checks++;
        if (bad_hdr_cnt !== 8'd1 || frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL badhdr_counts: got bad_hdr=%0d frames=%0d expected 1 and 4", bad_hdr_cnt, frame_cnt);
        end
    endtask

    task automatic test_bad_chip();
        chips_t ch;
        int exp_addr [10];
        logic [5:0] exp_en;
        int k;
        ch       = '{0, 6, 1, 7, 2, 3, 4, 5, 0, 1};
        exp_addr = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        @(negedge clk);
        in_valid6 = 1'b1;
        in_frame6 = mk_frame(46'h0, ch, 18'h03000);
        @(negedge clk);
        in_valid6 = 1'b0;
        for (int i = 2; i <= 11; i++) begin
            @(negedge clk);
            k      = i - 2;
            exp_en = (ch[k] < 3'd6) ? 6'(1 << ch[k]) : 6'd0;
            checks++;
            if (wr_en6 !== exp_en || (exp_en != 6'd0 &&
                (wr_addr6 !== 7'(exp_addr[k]) || wr_data6 !== {ch[k], 18'h03000 + 18'(k)}))) begin
                errors++;
                $display("FAIL badchip_pkt%0d: got en=%h addr=%0d data=%h expected en=%h addr=%0d data=%h",
                         k, wr_en6, wr_addr6, wr_data6, exp_en, exp_addr[k], {ch[k], 18'h03000 + 18'(k)});
            end
        end
        @(negedge clk);
        checks++;
        if (bad_chip_cnt6 !== 8'd2 || frame_cnt6 !== 16'd1) begin
            errors++;
            $display("FAIL badchip_counts: got bad_chip=%0d frames=%0d expected 2 and 1", bad_chip_cnt6, frame_cnt6);
        end
    endtask

    task automatic test_wrap_flush();
        chips_t ch;
        int bad;
        ch = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fq.delete();
        for (int f = 0; f < 13; f++) fq.push_back(mk_frame(46'h0, ch, 18'(f * 16)));
        run_frames();
        checks++;
        if (w_cyc.size() != 130) begin
            errors++;
            $display("FAIL wrap_write_count: got %0d expected 130", w_cyc.size());
        end
        bad = 0;
        for (int k = 0; k < w_cyc.size(); k++) begin
            if (w_en[k] !== 8'h01 || w_addr[k] !== 7'(k % 128)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_addr_seq: got %0d bad addresses expected 0", bad);
        end
        checks++;
        if (wrap !== 8'h01) begin
            errors++;
            $display("FAIL wrap_flag_set: got %h expected 01", wrap);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (wrap !== 8'h00) begin
            errors++;
            $display("FAIL wrap_flag_flush: got %h expected 00", wrap);
        end
        fq.delete();
        fq.push_back(mk_frame(46'h0, ch, 18'h00500));
        run_frames();
        checks++;
        if (w_cyc.size() != 10 || w_addr[0] !== 7'd0 || w_addr[1] !== 7'd1) begin
            errors++;
            $display("FAIL flush_restart_addr: got writes=%0d first addr=%0d expected 10 writes from addr 0",
                     w_cyc.size(), (w_addr.size() > 0) ? int'(w_addr[0]) : -1);
        end
        checks++;
        if (frame_cnt !== 16'd18) begin
            errors++;
            $display("FAIL wrap_frame_cnt: got %0d expected 18", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        chips_t ch;
        chips_t ch2;
        int n_wr;
        int n_done;
        ch  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        ch2 = '{5, 4, 3, 2, 1, 0, 7, 6, 5, 4};
        @(negedge clk);
        in_valid = 1'b1;
        in_frame = mk_frame(46'h0, ch, 18'h02000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        // Packet 4 is being processed; packet 3 (chip 3) is on the outputs.
        checks++;
        if (wr_en !== 8'h08) begin
            errors++;
            $display("FAIL midrst_pre_write: got en=%h expected 08", wr_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 8'h00 || frame_done !== 1'b0 || wr_addr !== 7'd0 || wr_data !== 21'd0) begin
            errors++;
            $display("FAIL midrst_immediate: got en=%h done=%b addr=%0d data=%h expected all zero",
                     wr_en, frame_done, wr_addr, wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        n_wr   = 0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_en !== 8'h00) n_wr++;
            if (frame_done !== 1'b0) n_done++;
        end
        checks++;
        if (n_wr != 0 || n_done != 0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_abandon: got writes=%0d done=%0d frames=%0d expected 0,0,0", n_wr, n_done, frame_cnt);
        end
        fq.delete();
        fq.push_back(mk_frame(46'h0, ch2, 18'h02A00));
        run_frames();
        checks++;
        if (w_cyc.size() != 10 || w_cyc[0] != 2 || w_en[0] !== 8'h20 || w_data[0] !== {3'd5, 18'h02A00}) begin
            errors++;
            $display("FAIL midrst_restart: got writes=%0d first en=%h data=%h expected 10 writes first en=20 data=%h",
                     w_cyc.size(), (w_en.size() > 0) ? w_en[0] : 8'h00,
                     (w_data.size() > 0) ? w_data[0] : 21'h0, {3'd5, 18'h02A00});
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != 11 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_done: got pulses=%0d frames=%0d expected 1 pulse at 11 and 1 frame", d_cyc.size(), frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_header();
        test_bad_chip();
        test_wrap_flush();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
